// File: rtl/chipper_pkg.sv
// rtl/chipper_pkg.sv - shared channel constants, defaults and dest-field helper for the CHIPPER stage
package chipper_pkg;

    localparam int NUM_CH     = 4;
    localparam int CH_E       = 0;
    localparam int CH_W       = 1;
    localparam int CH_N       = 2;
    localparam int CH_S       = 3;
    localparam int DEF_FLIT_W = 10;
    localparam int DEF_DEST_W = 6;

    // Destination lives in the low bits of the flit; returned zero-extended to 32 bits.
    function automatic logic [31:0] dest_field(input logic [31:0] flit, input int unsigned dest_w);
        return flit & ((32'd1 << dest_w) - 32'd1);
    endfunction

endpackage

// File: rtl/chipper_flit_fifo.sv
// rtl/chipper_flit_fifo.sv - circular local-injection FIFO with wrap-bit pointers and level output
module chipper_flit_fifo
    import chipper_pkg::*;
#(
    parameter int FLIT_W = DEF_FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [FLIT_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [FLIT_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;

    assign o_level = r_wr - r_rd;
    assign o_full  = (o_level == (AW+1)'(DEPTH));
    assign o_empty = (r_wr == r_rd);
    assign o_head  = r_mem[r_rd[AW-1:0]];

    // Full/empty come from registered pointers only, so a push while full is refused
    // even if the same cycle pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push && !o_full)
                r_wr <= r_wr + 1'b1;
            if (i_pop && !o_empty)
                r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full)
            r_mem[r_wr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/chipper_inject_eject.sv
// rtl/chipper_inject_eject.sv - deflection-router eject/inject stage with local FIFO and starvation flag
module chipper_inject_eject
    import chipper_pkg::*;
#(
    parameter int                FLIT_W     = DEF_FLIT_W,
    parameter int                DEST_W     = DEF_DEST_W,
    parameter logic [DEST_W-1:0] MY_ID      = '0,
    parameter int                DEPTH      = 4,
    parameter int                STARVE_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*FLIT_W-1:0]   in_flit,
    input  logic                       inj_valid,
    input  logic [FLIT_W-1:0]          inj_flit,
    output logic                       inj_ready,
    output logic [NUM_CH-1:0]          out_valid,
    output logic [NUM_CH*FLIT_W-1:0]   out_flit,
    output logic                       ej_valid,
    output logic [FLIT_W-1:0]          ej_flit,
    output logic                       starve,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic                      w_full;
    logic                      w_empty;
    logic [FLIT_W-1:0]         w_head;
    logic [NUM_CH-1:0]         w_match;
    logic                      w_ej_hit;
    logic [1:0]                w_ej_idx;
    logic [FLIT_W-1:0]         w_ej_data;
    logic [NUM_CH-1:0]         w_after;
    logic                      w_inj_hit;
    logic [1:0]                w_inj_idx;
    logic [NUM_CH*FLIT_W-1:0]  w_next_flit;
    logic [CNT_W-1:0]          w_cnt_next;

    logic [NUM_CH-1:0]         r_out_valid;
    logic [NUM_CH*FLIT_W-1:0]  r_out_flit;
    logic                      r_ej_valid;
    logic [FLIT_W-1:0]         r_ej_flit;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_starve;

    chipper_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (inj_valid && !w_full),
        .i_push_data (inj_flit),
        .i_pop       (w_inj_hit),
        .o_head      (w_head),
        .o_level     (fifo_level),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign inj_ready = !w_full;

    // Eject the lowest-index matching flit; later matches are deflected onward.
    always_comb begin
        w_match  = '0;
        w_ej_hit = 1'b0;
        w_ej_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_match[i] = in_valid[i] &&
                (dest_field(32'(in_flit[i*FLIT_W +: FLIT_W]), DEST_W) == 32'(MY_ID));
            if (w_match[i] && !w_ej_hit) begin
                w_ej_hit = 1'b1;
                w_ej_idx = 2'(i);
            end
        end
        w_ej_data = in_flit[w_ej_idx*FLIT_W +: FLIT_W];
        w_after   = in_valid & ~(w_ej_hit ? (NUM_CH'(1) << w_ej_idx) : '0);
    end

    // Inject FIFO head into the lowest free slot, including one just freed by eject.
    always_comb begin
        w_inj_hit   = 1'b0;
        w_inj_idx   = '0;
        w_next_flit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_empty && !w_after[i] && !w_inj_hit) begin
                w_inj_hit = 1'b1;
                w_inj_idx = 2'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_after[i])
                w_next_flit[i*FLIT_W +: FLIT_W] = in_flit[i*FLIT_W +: FLIT_W];
            else if (w_inj_hit && (w_inj_idx == 2'(i)))
                w_next_flit[i*FLIT_W +: FLIT_W] = w_head;
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_empty || w_inj_hit)
            w_cnt_next = '0;
        else if (r_cnt != CNT_W'(STARVE_MAX))
            w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_flit  <= '0;
            r_ej_valid  <= 1'b0;
            r_ej_flit   <= '0;
            r_cnt       <= '0;
            r_starve    <= 1'b0;
        end else begin
            r_out_valid <= w_after | (w_inj_hit ? (NUM_CH'(1) << w_inj_idx) : '0);
            r_out_flit  <= w_next_flit;
            r_ej_valid  <= w_ej_hit;
            if (w_ej_hit)
                r_ej_flit <= w_ej_data;
            r_cnt       <= w_cnt_next;
            r_starve    <= (w_cnt_next == CNT_W'(STARVE_MAX));
        end
    end

    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign ej_valid  = r_ej_valid;
    assign ej_flit   = r_ej_flit;
    assign starve    = r_starve;

endmodule
